// File: rtl/arp_rx_parser.sv
// ARP payload parser: validates the fixed header, publishes sender bindings to the
// cache and queues replies-to-send for requests that target the local IP.
module arp_rx_parser #(
  parameter int FIFO_DEPTH       = 4,
  parameter bit ALLOW_GRATUITOUS = 1'b1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tlast,
  input  logic [31:0]          local_ip_addr,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic [31:0]          req_ip,
  output logic [47:0]          req_mac,
  output logic                 learn_valid,
  output logic [31:0]          learn_ip,
  output logic [47:0]          learn_mac,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] ovf_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {PARSE, DRAIN, DROP} state_t;

  state_t        state_reg;
  logic [4:0]    b_reg;
  logic          hdr_ok_reg;
  logic [7:0]    oper_reg;
  logic [47:0]   sha_reg;
  logic [31:0]   spa_reg;
  logic [23:0]   tpa_hi_reg;

  logic          byte_ok;
  logic [31:0]   tpa;
  logic          eval, match, frame_ok, is_req, is_rep;
  logic          do_push, do_learn, do_drop;

  // Required header byte values; OPER low byte admits request or reply only.
  always_comb begin
    byte_ok = 1'b1;
    case (b_reg)
      5'd0:    byte_ok = (s_tdata == 8'h00);
      5'd1:    byte_ok = (s_tdata == 8'h01);
      5'd2:    byte_ok = (s_tdata == 8'h08);
      5'd3:    byte_ok = (s_tdata == 8'h00);
      5'd4:    byte_ok = (s_tdata == 8'h06);
      5'd5:    byte_ok = (s_tdata == 8'h04);
      5'd6:    byte_ok = (s_tdata == 8'h00);
      5'd7:    byte_ok = (s_tdata == 8'h01) || (s_tdata == 8'h02);
      default: byte_ok = 1'b1;
    endcase
  end

  // The TPA low byte is still on the bus at the evaluation edge.
  assign tpa      = {tpa_hi_reg, s_tdata};
  assign eval     = (state_reg == PARSE) && s_tvalid && (b_reg == 5'd27);
  assign is_req   = (oper_reg == 8'd1);
  assign is_rep   = (oper_reg == 8'd2);
  assign frame_ok = hdr_ok_reg && (is_req || is_rep);
  assign match    = (tpa == local_ip_addr) && (local_ip_addr != 32'd0);
  assign do_push  = eval && frame_ok && is_req && match;
  assign do_learn = eval && frame_ok &&
                    (match || (ALLOW_GRATUITOUS && (spa_reg == tpa) && (spa_reg != local_ip_addr)));
  assign do_drop  = (state_reg == PARSE) && s_tvalid &&
                    (((b_reg < 5'd27) && (s_tlast || ((b_reg <= 5'd7) && !byte_ok))) ||
                     (eval && !frame_ok));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= PARSE;
      b_reg      <= 5'd0;
      hdr_ok_reg <= 1'b1;
      oper_reg   <= 8'd0;
      sha_reg    <= 48'd0;
      spa_reg    <= 32'd0;
      tpa_hi_reg <= 24'd0;
    end else if (s_tvalid) begin
      case (state_reg)
        PARSE: begin
          if (!byte_ok) hdr_ok_reg <= 1'b0;
          if (b_reg == 5'd7) oper_reg <= s_tdata;
          if (b_reg >= 5'd8 && b_reg <= 5'd13) sha_reg <= {sha_reg[39:0], s_tdata};
          if (b_reg >= 5'd14 && b_reg <= 5'd17) spa_reg <= {spa_reg[23:0], s_tdata};
          if (b_reg >= 5'd24 && b_reg <= 5'd26) tpa_hi_reg <= {tpa_hi_reg[15:0], s_tdata};
          if (s_tlast) begin
            b_reg      <= 5'd0;
            hdr_ok_reg <= 1'b1;
          end else if (b_reg == 5'd27) begin
            state_reg <= DRAIN;
          end else if ((b_reg <= 5'd7) && !byte_ok) begin
            state_reg <= DROP;
          end else begin
            b_reg <= b_reg + 5'd1;
          end
        end
        DRAIN, DROP: begin
          if (s_tlast) begin
            state_reg  <= PARSE;
            b_reg      <= 5'd0;
            hdr_ok_reg <= 1'b1;
          end
        end
        default: state_reg <= PARSE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      learn_valid <= 1'b0;
      learn_ip    <= 32'd0;
      learn_mac   <= 48'd0;
    end else begin
      learn_valid <= do_learn;
      if (do_learn) begin
        learn_ip  <= spa_reg;
        learn_mac <= sha_reg;
      end
    end
  end

  // Pending-reply FIFO, first-word-fall-through; a pop frees room for a same-cycle push.
  logic [79:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop, full, wr_en, ovf_inc;

  assign req_valid = (count_reg != '0);
  assign pop       = req_valid && req_ready;
  assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign wr_en     = do_push && (!full || pop);
  assign ovf_inc   = do_push && full && !pop;
  assign req_ip    = req_valid ? mem[rd_ptr_reg][79:48] : 32'd0;
  assign req_mac   = req_valid ? mem[rd_ptr_reg][47:0]  : 48'd0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {spa_reg, sha_reg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (do_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      if (ovf_inc && (ovf_cnt != '1))  ovf_cnt  <= ovf_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: doc/arp_rx_parser.md
# arp_rx_parser

Parametrised ARP receive parser for the UDP/IP stack. It consumes the byte stream of an ARP payload after the Ethernet header has been stripped and validates the fixed header fields. It decodes request and reply opcodes and publishes learned sender bindings to the ARP cache. Requests addressed to the local IP are queued in a FIFO of pending replies for the ARP transmit block, so back-to-back requests are not lost while a reply is being sent.

## Interface
Parameters:
- FIFO_DEPTH, 4, pending-reply FIFO entries; power of two, at least 2.
- ALLOW_GRATUITOUS, 1, when 1, gratuitous ARP (SPA == TPA) updates the cache.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- s_tdata  in  8  ARP payload byte.
- s_tvalid  in  1  byte qualifier; there is no backpressure.
- s_tlast  in  1  last byte of the frame.
- local_ip_addr  in  32  local IP; 0 means unconfigured and disables all matching.
- req_valid  out  1  a pending reply entry is available.
- req_ready  in  1  the transmit block consumes the entry.
- req_ip  out  32  requester IP (SPA).
- req_mac  out  48  requester MAC (SHA).
- learn_valid  out  1  one-cycle pulse: a cache binding is available.
- learn_ip  out  32  binding IP.
- learn_mac  out  48  binding MAC.
- drop_cnt  out  CNT_WIDTH  frames that were malformed or truncated; saturates.
- ovf_cnt  out  CNT_WIDTH  requests lost because the FIFO was full; saturates.

## Operation
Byte map, indexed by the accepted-byte index b:

| Bytes | Field | Required value |
|---|---|---|
| 0-1 | HTYPE | 0x0001 |
| 2-3 | PTYPE | 0x0800 |
| 4 | HLEN | 6 |
| 5 | PLEN | 4 |
| 6-7 | OPER | 1 = request, 2 = reply |
| 8-13 | SHA | — |
| 14-17 | SPA | — |
| 18-23 | THA | — |
| 24-27 | TPA | — |

- All multi-byte fields are big-endian; the first byte received is the MSB.
- State machine has three states: PARSE, DRAIN, DROP.
  - PARSE: a 5-bit counter b advances on every accepted byte. Fields are captured into registers. A header-valid flag clears on any byte that mismatches the required values for b = 0..7.
  - s_tlast with b < 27: the frame is truncated. Increment drop_cnt, clear b, stay in PARSE.
  - Byte 27 accepted without s_tlast: evaluate, then go to DRAIN.
  - Byte 27 accepted with s_tlast: evaluate, clear b, stay in PARSE.
  - Header mismatch detected at b ≤ 7 without s_tlast: go to DROP.
  - DRAIN: discard bytes (Ethernet padding) until s_tlast, then clear b and return to PARSE.
  - DROP: identical to DRAIN, except drop_cnt increments once on entry.
- Evaluation is performed on the byte-27 edge, using the live TPA low byte from s_tdata together with the registered fields.
  - Invalid header or OPER not in {1, 2}: increment drop_cnt. No other action.
  - match = (TPA == local_ip_addr) && (local_ip_addr != 0).
  - Request with match: push {SPA, SHA} into the FIFO, and issue learn with SPA/SHA.
  - Reply with match: issue learn with SPA/SHA.
  - SPA == TPA, ALLOW_GRATUITOUS = 1, and SPA != local_ip_addr: issue learn regardless of match. No push.
  - Otherwise the frame is ignored silently and is not counted as a drop.
- FIFO is first-word-fall-through: req_ip/req_mac reflect the head entry whenever req_valid = 1. An entry pops on req_valid && req_ready.
- Push while full with no simultaneous pop: discard the entry and increment ovf_cnt. Push while full with a simultaneous pop: accept the entry.
- Both counters saturate at all-ones.

## Timing
- Reset values:
  - req_valid = 0.
  - learn_valid = 0.
  - learn_ip, learn_mac, req_ip, req_mac = 0.
  - Both counters = 0.
  - FIFO empty, b = 0, state PARSE.
- Reset takes effect in any state, including mid-frame. The upstream block guarantees that reset deasserts on a frame boundary.
- Edge E is the edge at which byte 27 is accepted.
  - learn_valid is high for exactly the cycle after E, with learn_ip/learn_mac stable during that cycle.
  - A FIFO write occurs at E. req_valid rises in the cycle after E if the FIFO was empty.
- Pop occurs at the edge where req_valid && req_ready. The next entry, if any, is presented the following cycle with no bubble.
- A new frame can start on the cycle immediately after s_tlast. Sustained full-rate 28-byte frames must be handled with no lost beats.

## Test plan
- Valid request:
  - Stimulus: TPA = 192.168.1.10 = local_ip_addr, SHA = 00:0A:35:01:02:03, SPA = 192.168.1.1, 18 pad bytes.
  - Required: learn_valid pulses one cycle after byte 27 with SPA/SHA; req_valid = 1 with req_ip = 0xC0A80101 and req_mac = 0x000A35010203; the pad bytes are ignored.
- Five back-to-back requests (SPA = .1 through .5), FIFO_DEPTH = 4, req_ready held low:
  - Required: four entries are stored and ovf_cnt = 1.
  - Then raise req_ready: entries .1 to .4 pop on consecutive cycles.
- Reply with matching TPA:
  - Required: learn pulse with sender data; req_valid stays 0.
- Invalid header and truncation:
  - HTYPE = 0x0006: drop_cnt = 1, no learn, no push.
  - A frame whose s_tlast arrives at b = 15: drop_cnt = 2.
  - A subsequent valid frame is parsed correctly.
- Gratuitous ARP (SPA = TPA = 10.0.0.7, local IP = 10.0.0.1):
  - ALLOW_GRATUITOUS = 1: learn pulse.
  - ALLOW_GRATUITOUS = 0: no learn.
  - local_ip_addr = 0 with a request whose TPA = 0: no push.
- Reset between bytes 10 and 11 of a frame with 2 FIFO entries pending:
  - Required: FIFO empty, req_valid = 0, counters = 0.
  - The next full frame is parsed correctly.
